// File: rtl/spi_txn_arbiter_if.sv
// Requester and SPI-master side signals of spi_txn_arbiter.
// slave  : seen from the arbiter (requests and master status in, grants and master controls out)
// master : seen from the environment driving the arbiter
interface spi_txn_arbiter_if;
    logic [1:0] i_req;
    logic [3:0] i_len0;
    logic [3:0] i_len1;
    logic [7:0] i_txd0;
    logic [7:0] i_txd1;
    logic [1:0] i_tx_valid;
    logic [1:0] o_tx_ready;
    logic [1:0] o_grant;
    logic [7:0] o_rx_data;
    logic [1:0] o_rx_valid;
    logic [1:0] o_done;
    logic       o_err;
    logic       o_spi_tx_en;
    logic [7:0] o_spi_data_tx;
    logic       i_spi_busy;
    logic [7:0] i_spi_rx_data;

    modport slave (
        input  i_req, i_len0, i_len1, i_txd0, i_txd1, i_tx_valid,
        input  i_spi_busy, i_spi_rx_data,
        output o_tx_ready, o_grant, o_rx_data, o_rx_valid, o_done, o_err,
        output o_spi_tx_en, o_spi_data_tx
    );

    modport master (
        output i_req, i_len0, i_len1, i_txd0, i_txd1, i_tx_valid,
        output i_spi_busy, i_spi_rx_data,
        input  o_tx_ready, o_grant, o_rx_data, o_rx_valid, o_done, o_err,
        input  o_spi_tx_en, o_spi_data_tx
    );
endinterface

// File: rtl/spi_txn_arbiter.sv
// Two-port round-robin arbiter and multi-byte sequencer in front of a
// single-byte SPI master. A granted requester owns the master for a whole
// transaction of 1..16 bytes; each byte is launched with a fresh rising edge
// of o_spi_tx_en and completes once busy has been seen high and then low.
//
// Optional build macro SPI_TIMEOUT_EN: enables a watchdog in START/WAIT that
// aborts the transaction after TIMEOUT cycles and pulses o_err.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no owner; arbitrate pending requests, latch owner's length
// LOAD    | wait for owner's tx byte (or abort if owner drops its request)
// START   | o_spi_tx_en high until the master reports busy
// WAIT    | master shifting; capture rx byte when busy falls
// DONE    | present rx byte to owner; decide next byte or release
// GAP     | idle spacing between consecutive bytes
// RELEASE | pulse o_done, drop grant, advance round-robin pointer
module spi_txn_arbiter #(
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    spi_txn_arbiter_if.slave bus
);

`ifdef SPI_TIMEOUT_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif
    localparam int unsigned WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_START   = 3'd2,
        S_WAIT    = 3'd3,
        S_DONE    = 3'd4,
        S_GAP     = 3'd5,
        S_RELEASE = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic [1:0]      grant_q, grant_d;
    logic            rr_q, rr_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [3:0]      gap_q, gap_d;
    logic            tx_en_q, tx_en_d;
    logic [7:0]      data_tx_q, data_tx_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            err_q, err_d;
    logic [WD_W-1:0] wd_q, wd_d;

    logic       own_req;
    logic       own_valid;
    logic [7:0] own_txd;
    logic       pick;
    logic       wd_hit;

    assign own_req   = bus.i_req[owner_q];
    assign own_valid = bus.i_tx_valid[owner_q];
    assign own_txd   = owner_q ? bus.i_txd1 : bus.i_txd0;
    // rr_q names the requester favoured when both ask at once
    assign pick      = (bus.i_req == 2'b11) ? rr_q : bus.i_req[1];
    assign wd_hit    = WD_EN && (wd_q == WD_W'(TIMEOUT - 1));

    // State and datapath registers; async reset clears everything incl. tx_en and grant
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            owner_q   <= 1'b0;
            grant_q   <= 2'b00;
            rr_q      <= 1'b0;
            cnt_q     <= 4'd0;
            gap_q     <= 4'd0;
            tx_en_q   <= 1'b0;
            data_tx_q <= 8'd0;
            rx_data_q <= 8'd0;
            err_q     <= 1'b0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            tx_en_q   <= tx_en_d;
            data_tx_q <= data_tx_d;
            rx_data_q <= rx_data_d;
            err_q     <= err_d;
            wd_q      <= wd_d;
        end
    end

    // Next-state logic for the transaction sequencer
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        tx_en_d   = tx_en_q;
        data_tx_d = data_tx_q;
        rx_data_d = rx_data_q;
        err_d     = 1'b0;
        wd_d      = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.i_req != 2'b00) begin
                    owner_d = pick;
                    grant_d = pick ? 2'b10 : 2'b01;
                    cnt_d   = pick ? bus.i_len1 : bus.i_len0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // a dropped request wins over a simultaneously offered byte
                if (!own_req) begin
                    state_d = S_RELEASE;
                end else if (own_valid) begin
                    data_tx_d = own_txd;
                    tx_en_d   = 1'b1;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (bus.i_spi_busy) begin
                    tx_en_d = 1'b0;
                    state_d = S_WAIT;
                end else if (wd_hit) begin
                    tx_en_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_RELEASE;
                end
            end
            S_WAIT: begin
                if (!bus.i_spi_busy) begin
                    rx_data_d = bus.i_spi_rx_data;
                    state_d   = S_DONE;
                end else if (wd_hit) begin
                    err_d   = 1'b1;
                    state_d = S_RELEASE;
                end
            end
            S_DONE: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RELEASE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (GAP_CYCLES == 0) begin
                        state_d = S_LOAD;
                    end else begin
                        gap_d   = 4'(GAP_CYCLES - 1);
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == 4'd0) begin
                    state_d = S_LOAD;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            S_RELEASE: begin
                grant_d = 2'b00;
                rr_d    = ~owner_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = 2'b00;
                tx_en_d = 1'b0;
            end
        endcase

        // watchdog restarts from zero on every state entry
        if (WD_EN && (state_d == state_q) &&
            ((state_q == S_START) || (state_q == S_WAIT))) begin
            wd_d = wd_q + WD_W'(1);
        end
    end

    assign bus.o_grant       = grant_q;
    assign bus.o_tx_ready    = (state_q == S_LOAD && own_req && own_valid) ? grant_q : 2'b00;
    assign bus.o_rx_data     = rx_data_q;
    assign bus.o_rx_valid    = (state_q == S_DONE) ? grant_q : 2'b00;
    assign bus.o_done        = (state_q == S_RELEASE) ? grant_q : 2'b00;
    assign bus.o_err         = WD_EN ? err_q : 1'b0;
    assign bus.o_spi_tx_en   = tx_en_q;
    assign bus.o_spi_data_tx = data_tx_q;

endmodule

// File: doc/spi_txn_arbiter.md
Name: spi_txn_arbiter

Overview:
- Multi-byte transaction sequencer and two-port round-robin arbiter in front of the single-byte SPI master.
- Grants the SPI master to one of two requesters for a whole transaction of 1..16 bytes, then feeds bytes one at a time.
- Launches each byte with the master's rising-edge enable and detects byte completion from the master's busy flag.
- Returns each received byte to the granted requester.

Parameters:
- GAP_CYCLES, 2, idle i_clk cycles inserted between consecutive bytes of one transaction (0..15).
- TIMEOUT, 32, watchdog limit in i_clk cycles; used only with SPI_TIMEOUT_EN.

Ports:
- i_clk  in  1  system clock; all logic on posedge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req  in  2  per-requester transaction request, level; held until o_done.
- i_len0  in  4  requester 0 length; bytes = value+1.
- i_len1  in  4  requester 1 length; bytes = value+1.
- i_txd0  in  8  requester 0 next transmit byte.
- i_txd1  in  8  requester 1 next transmit byte.
- i_tx_valid  in  2  per-requester transmit byte valid.
- o_tx_ready  out  2  per-requester transmit byte accepted; one-hot, one-cycle pulse.
- o_grant  out  2  one-hot current owner; 00 when idle.
- o_rx_data  out  8  received byte, shared by both requesters.
- o_rx_valid  out  2  per-requester one-cycle pulse qualifying o_rx_data.
- o_done  out  2  per-requester one-cycle pulse at transaction end.
- o_err  out  1  one-cycle watchdog abort pulse; tied 0 without SPI_TIMEOUT_EN.
- o_spi_tx_en  out  1  to master enable input; master acts on its rising edge.
- o_spi_data_tx  out  8  to master transmit byte.
- i_spi_busy  in  1  from master busy flag.
- i_spi_rx_data  in  8  from master received byte.

Behaviour:
- Reset values: all outputs 0, state IDLE, round-robin pointer favours requester 0, byte counter 0.
- Clock and reset: one clock i_clk; reset i_rst_n is asynchronous, active-low.
- States: IDLE, LOAD, START, WAIT, DONE, GAP, RELEASE.
- IDLE:
  - If i_req != 0, grant and latch the owner's length into a 4-bit down-counter, then go to LOAD.
  - If both requesters request, grant the one not granted last.
  - o_grant asserts the cycle after the decision and holds until RELEASE completes.
- LOAD:
  - If the owner's i_tx_valid=1: pulse o_tx_ready for one cycle, latch the byte into o_spi_data_tx, go to START.
  - If the owner's i_req=0: abort and go to RELEASE.
- START:
  - Drive o_spi_tx_en=1 until i_spi_busy=1 is sampled, then drop it and go to WAIT.
  - o_spi_tx_en must be low for at least 1 cycle before each assertion, so every byte presents a fresh rising edge.
  - o_spi_data_tx is stable from LOAD until WAIT exits.
- WAIT:
  - On sampling i_spi_busy=0, capture i_spi_rx_data and go to DONE.
- DONE:
  - o_rx_data holds the captured byte; pulse the owner's o_rx_valid bit.
  - If the counter is 0, go to RELEASE. Otherwise decrement and go to GAP.
  - There is no backpressure on rx.
- GAP:
  - Count GAP_CYCLES cycles, then go to LOAD. GAP_CYCLES=0 goes straight to LOAD.
- RELEASE:
  - Pulse the owner's o_done for one cycle, clear o_grant, update the round-robin pointer, return to IDLE.
  - Re-arbitration is possible the next cycle.
- Requests arriving mid-transaction wait; i_len is sampled only in IDLE.
- An i_req drop outside LOAD is ignored until the next byte boundary.
- Reset mid-transaction:
  - Immediately drops o_spi_tx_en and o_grant.
  - The master is expected to be reset by the same i_rst_n.
- A byte is counted complete only after busy has been seen high, then low.

Optional Feature:
- Macro SPI_TIMEOUT_EN.
- When defined:
  - A watchdog counter runs in START and WAIT.
  - If it reaches TIMEOUT cycles without the expected i_spi_busy edge: drop o_spi_tx_en, pulse o_err, skip o_rx_valid for that byte, go to RELEASE (o_done still pulses).
  - The counter clears on every state entry.
- When undefined:
  - No watchdog; o_err is constant 0.
  - START and WAIT wait indefinitely.

Test Plan:
- Req0 only, i_len0=0, byte 8'hA5; master model busy 10 cycles, returns 8'h3C -> one tx_en rising edge, o_rx_valid=01 with 8'h3C, o_done=01, o_grant back to 00.
- Req0, i_len0=3, bytes 11,22,33,44, GAP_CYCLES=2 -> four tx_en rising edges, at least 2 idle cycles between busy-fall and next tx_en, four o_rx_valid pulses in order.
- i_req=11 held continuously, both lengths 0 -> grants alternate 01,10,01,10 after reset.
- Req1 drops i_req while in LOAD after the first of 4 bytes -> o_done=10, no further tx_en pulses, o_grant to 00.
- i_rst_n low during WAIT of byte 2 -> all outputs 0 immediately; after release, a new req1 transaction completes normally.
- With SPI_TIMEOUT_EN, TIMEOUT=32, master never raises busy -> o_err pulse 32 cycles after tx_en rises, o_done pulses, no o_rx_valid.
